// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying one control word and one data word
// across a pipeline boundary. The producer uses the master modport and the
// consumer uses the slave modport.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 133
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Moves a control bundle and a data bundle from in_if to out_if with one
// cycle of latency under valid/ready. SKID=1 adds a second entry so that
// In_Ready comes straight from a flop; SKID=0 keeps one entry and a
// combinational In_Ready. Flush squashes everything held, and a bubble
// always presents CTRL_RST so no write/branch enable leaks downstream.
// StallCnt counts saturating cycles spent stalled by the consumer.
module pipe_stage_reg #(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 133,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = 16
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    pipe_stage_reg_if.slave         in_if,
    pipe_stage_reg_if.master        out_if,
    input  logic                    Flush,
    input  logic                    Cnt_Clr,
    output logic [CNT_W-1:0]        StallCnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic                out_valid;
    logic                in_ready;
    logic                accept;
    logic                emit;

    // Handshake decode: the main entry is what the consumer sees.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_if.ready);
    assign accept    = in_if.valid && in_ready;
    assign emit      = out_valid && out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.ctrl  = out_valid ? main_ctrl_q : CTRL_RST;
    assign out_if.data  = main_data_q;
    assign StallCnt     = stall_cnt_q;

    // Next-state, entry steering and stall counter update.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (Flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                    end
                end
                ST_FULL: begin
                    if (accept && emit) begin
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                    end else if (accept && (SKID != 0)) begin
                        state_d     = ST_SKID;
                        skid_ctrl_d = in_if.ctrl;
                        skid_data_d = in_if.data;
                    end else if (emit) begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        state_d     = ST_FULL;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Registering the decode of the next state keeps Out_Ready off the In_Ready path.
        in_ready_d = (state_d != ST_SKID);

        stall_cnt_d = stall_cnt_q;
        if (Cnt_Clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_if.ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, entry and counter registers with asynchronous reset.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: the entry storage is reset too, so Out_Data reads zero straight out of reset.
            state_q     <= ST_EMPTY;
            main_ctrl_q <= CTRL_RST;
            main_data_q <= '0;
            skid_ctrl_q <= CTRL_RST;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
